// File: rtl/riscv_bus_arb_if.sv
// Dual-port memory bus: independent read and write channels, each with a request/grant handshake.
// Read data returns one cycle after a read grant.
interface dualport_bus #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            rd_req;
    logic [3:0]      rd_be;
    logic [AW-1:0]   rd_addr;
    logic            rd_gnt;
    logic [DW-1:0]   rd_data;
    logic            wr_req;
    logic [3:0]      wr_be;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_gnt;

    modport master (
        output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/riscv_bus_arb.sv
// Read-channel arbiter between instruction fetch and load/store onto one memory port.
// Stalled reads lock the owner; a bounded-wait counter keeps fetch from starving.
module riscv_bus_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dualport_bus.slave  ifu_port,
    dualport_bus.slave  lsu_port,
    dualport_bus.master mem_port
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic       LP_IFU      = 1'b0;
    localparam logic       LP_LSU      = 1'b1;

    logic       r_lock_vld;
    logic       r_lock_id;
    logic       r_resp_vld;
    logic       r_resp_id;
    logic [3:0] r_wait_cnt;

    logic       w_sel;
    logic       w_sel_req;
    logic       w_stall;
    logic       w_grant;
    logic       w_ifu_gnt;
    logic       w_lsu_gnt;
    logic       w_unused_ifu_wr;

    // Owner selection: an outstanding stall always wins, then a starved fetch.
    always_comb begin
        w_sel = LP_IFU;
        if (r_lock_vld) begin
            w_sel = r_lock_id;
        end else if (ifu_port.rd_req && (r_wait_cnt == LP_MAX_WAIT)) begin
            w_sel = LP_IFU;
        end else if (lsu_port.rd_req) begin
            w_sel = LP_LSU;
        end else begin
            w_sel = LP_IFU;
        end
    end

    assign w_sel_req = (w_sel == LP_LSU) ? lsu_port.rd_req : ifu_port.rd_req;
    assign w_stall   = w_sel_req && !mem_port.rd_gnt;
    assign w_grant   = w_sel_req && mem_port.rd_gnt;

    assign mem_port.rd_req  = w_sel_req;
    assign mem_port.rd_be   = !w_sel_req ? '0
                            : ((w_sel == LP_LSU) ? lsu_port.rd_be : ifu_port.rd_be);
    assign mem_port.rd_addr = !w_sel_req ? '0
                            : ((w_sel == LP_LSU) ? lsu_port.rd_addr : ifu_port.rd_addr);

    // Grants are forced low while reset is held so no requester sees a stray handshake.
    assign w_ifu_gnt = rst_n && (w_sel == LP_IFU) && mem_port.rd_gnt;
    assign w_lsu_gnt = rst_n && (w_sel == LP_LSU) && mem_port.rd_gnt;

    assign ifu_port.rd_gnt = w_ifu_gnt;
    assign lsu_port.rd_gnt = w_lsu_gnt;

    assign ifu_port.rd_data = (r_resp_vld && (r_resp_id == LP_IFU)) ? mem_port.rd_data : '0;
    assign lsu_port.rd_data = (r_resp_vld && (r_resp_id == LP_LSU)) ? mem_port.rd_data : '0;

    // Write channel belongs to load/store alone and is not arbitrated.
    assign mem_port.wr_req  = lsu_port.wr_req;
    assign mem_port.wr_be   = lsu_port.wr_be;
    assign mem_port.wr_addr = lsu_port.wr_addr;
    assign mem_port.wr_data = lsu_port.wr_data;
    assign lsu_port.wr_gnt  = mem_port.wr_gnt;
    assign ifu_port.wr_gnt  = 1'b0;

    assign w_unused_ifu_wr = ^{ifu_port.wr_req, ifu_port.wr_be,
                               ifu_port.wr_addr, ifu_port.wr_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
            r_resp_vld <= 1'b0;
            r_resp_id  <= 1'b0;
            r_wait_cnt <= 4'd0;
        end else begin
            // A stalled owner stays locked; a grant or a dropped request releases it.
            r_lock_vld <= w_stall;
            if (w_stall) begin
                r_lock_id <= w_sel;
            end

            r_resp_vld <= w_grant;
            if (w_grant) begin
                r_resp_id <= w_sel;
            end

            if (ifu_port.rd_req && !w_ifu_gnt) begin
                if (r_wait_cnt != LP_MAX_WAIT) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_bus_arb.sv
// Directed bench for riscv_bus_arb: arbitration order, lock, response routing,
// write pass-through and asynchronous reset.
module tb_riscv_bus_arb;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    dualport_bus ifu_if ();
    dualport_bus lsu_if ();
    dualport_bus mem_if ();

    riscv_bus_arb #(.MAX_WAIT(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ifu_port (ifu_if.slave),
        .lsu_port (lsu_if.slave),
        .mem_port (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'hDEAD_BEEF;
            32'h0000_0080: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (!rst_n)
            mem_if.rd_data <= 32'hCAFE_0000;
        else if (mem_if.rd_req && mem_if.rd_gnt)
            mem_if.rd_data <= mem_rd(mem_if.rd_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    // One bus cycle: drive after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic [31:0] la, input logic g);
        @(posedge clk);
        #1;
        ifu_if.rd_req  = ir;
        ifu_if.rd_addr = ia;
        lsu_if.rd_req  = lr;
        lsu_if.rd_addr = la;
        mem_if.rd_gnt  = g;
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        ifu_if.rd_req  = 1'b0; ifu_if.rd_be  = 4'hF; ifu_if.rd_addr = 32'h44;
        ifu_if.wr_req  = 1'b0; ifu_if.wr_be  = 4'h0; ifu_if.wr_addr = '0; ifu_if.wr_data = '0;
        lsu_if.rd_req  = 1'b1; lsu_if.rd_be  = 4'hF; lsu_if.rd_addr = 32'h2000;
        lsu_if.wr_req  = 1'b0; lsu_if.wr_be  = 4'h0; lsu_if.wr_addr = '0; lsu_if.wr_data = '0;
        mem_if.rd_gnt  = 1'b1;
        mem_if.wr_gnt  = 1'b0;

        // Held in reset with a pending request and a granting memory.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_lsu_gnt",  32'(lsu_if.rd_gnt), 32'h0);
        check_eq("rst_ifu_gnt",  32'(ifu_if.rd_gnt), 32'h0);
        check_eq("rst_mem_req",  32'(mem_if.rd_req), 32'h1);
        check_eq("rst_ifu_data", ifu_if.rd_data, 32'h0);
        check_eq("rst_lsu_data", lsu_if.rd_data, 32'h0);
        lsu_if.rd_req = 1'b0;
        rst_n = 1'b1;

        // Idle: address and byte enables gated to zero.
        cyc(1'b0, 32'h44, 1'b0, 32'h300, 1'b1);
        check_eq("idle_req",  32'(mem_if.rd_req), 32'h0);
        check_eq("idle_addr", mem_if.rd_addr, 32'h0);
        check_eq("idle_be",   32'(mem_if.rd_be), 32'h0);

        // Both request, memory always grants: lsu 0..3, fetch at 4.
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1);
            check_eq($sformatf("s24_lsu_gnt_c%0d", c), 32'(lsu_if.rd_gnt), 32'h1);
            check_eq($sformatf("s24_ifu_gnt_c%0d", c), 32'(ifu_if.rd_gnt), 32'h0);
            if (c > 0)
                check_eq($sformatf("s24_lsu_data_c%0d", c), lsu_if.rd_data, 32'hA5A5_2000);
        end
        cyc(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1);
        check_eq("s24_ifu_gnt_c4",  32'(ifu_if.rd_gnt), 32'h1);
        check_eq("s24_lsu_gnt_c4",  32'(lsu_if.rd_gnt), 32'h0);
        check_eq("s24_addr_c4",     mem_if.rd_addr, 32'h1000);
        check_eq("s24_lsu_data_c4", lsu_if.rd_data, 32'hA5A5_2000);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("s24_ifu_data_c5", ifu_if.rd_data, 32'hA5A5_1000);
        check_eq("s24_lsu_data_c5", lsu_if.rd_data, 32'h0);

        // lsu stalled three cycles; fetch joins from cycle 1.
        cyc(1'b0, 32'h1000, 1'b1, 32'h100, 1'b0);
        check_eq("s25_addr_c0", mem_if.rd_addr, 32'h100);
        cyc(1'b1, 32'h1000, 1'b1, 32'h100, 1'b0);
        cyc(1'b1, 32'h1000, 1'b1, 32'h100, 1'b0);
        check_eq("s25_addr_c2", mem_if.rd_addr, 32'h100);
        cyc(1'b1, 32'h1000, 1'b1, 32'h100, 1'b1);
        check_eq("s25_lsu_gnt_c3", 32'(lsu_if.rd_gnt), 32'h1);
        check_eq("s25_ifu_gnt_c3", 32'(ifu_if.rd_gnt), 32'h0);
        cyc(1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
        check_eq("s25_ifu_gnt_c4",  32'(ifu_if.rd_gnt), 32'h1);
        check_eq("s25_lsu_data_c4", lsu_if.rd_data, 32'hA5A5_0100);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("s25_ifu_data_c5", ifu_if.rd_data, 32'hA5A5_1000);

        // Long lsu stall saturates the fetch wait counter; lock must still hold.
        for (int c = 0; c < 6; c++)
            cyc(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
        check_eq("s27_locked_addr", mem_if.rd_addr, 32'h2000);
        cyc(1'b1, 32'h1000, 1'b0, 32'h2000, 1'b1);
        check_eq("s27_abort_req",     32'(mem_if.rd_req), 32'h0);
        check_eq("s27_abort_ifu_gnt", 32'(ifu_if.rd_gnt), 32'h0);
        cyc(1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
        check_eq("s27_ifu_gnt", 32'(ifu_if.rd_gnt), 32'h1);
        check_eq("s27_addr",    mem_if.rd_addr, 32'h1000);

        // Back-to-back grants to different requesters.
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        check_eq("s26_ifu_gnt_n",   32'(ifu_if.rd_gnt), 32'h1);
        check_eq("s26_prev_data_n", ifu_if.rd_data, 32'hA5A5_1000);
        cyc(1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        check_eq("s26_lsu_gnt_n1",  32'(lsu_if.rd_gnt), 32'h1);
        check_eq("s26_ifu_data_n1", ifu_if.rd_data, 32'hDEAD_BEEF);
        check_eq("s26_lsu_data_n1", lsu_if.rd_data, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("s26_lsu_data_n2", lsu_if.rd_data, 32'h1234_5678);
        check_eq("s26_ifu_data_n2", ifu_if.rd_data, 32'h0);

        // lsu write alongside a fetch read.
        lsu_if.wr_req = 1'b1; lsu_if.wr_be = 4'h3;
        lsu_if.wr_addr = 32'h200; lsu_if.wr_data = 32'h55AA_1234;
        ifu_if.wr_req = 1'b1; ifu_if.wr_be = 4'hF;
        ifu_if.wr_addr = 32'h999; ifu_if.wr_data = 32'hFFFF_FFFF;
        mem_if.wr_gnt = 1'b1;
        cyc(1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
        check_eq("s28_wr_req",  32'(mem_if.wr_req), 32'h1);
        check_eq("s28_wr_be",   32'(mem_if.wr_be), 32'h3);
        check_eq("s28_wr_addr", mem_if.wr_addr, 32'h200);
        check_eq("s28_wr_data", mem_if.wr_data, 32'h55AA_1234);
        check_eq("s28_lsu_wgnt", 32'(lsu_if.wr_gnt), 32'h1);
        check_eq("s28_ifu_wgnt", 32'(ifu_if.wr_gnt), 32'h0);
        check_eq("s28_ifu_gnt",  32'(ifu_if.rd_gnt), 32'h1);
        lsu_if.wr_req = 1'b0; ifu_if.wr_req = 1'b0; mem_if.wr_gnt = 1'b0;

        // Reset during a response cycle drops the returned data at once.
        cyc(1'b1, 32'h900, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("s29_resp_data", ifu_if.rd_data, 32'hA5A5_0900);
        #2 rst_n = 1'b0;
        #1 check_eq("s29_rst_data", ifu_if.rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while fetch holds a lock: the lock vanishes asynchronously.
        cyc(1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
        check_eq("s29_own_ifu", mem_if.rd_addr, 32'h600);
        cyc(1'b1, 32'h600, 1'b1, 32'h700, 1'b0);
        check_eq("s29_lock_ifu", mem_if.rd_addr, 32'h600);
        mem_if.rd_gnt = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("s29_rst_addr",    mem_if.rd_addr, 32'h700);
        check_eq("s29_rst_lsu_gnt", 32'(lsu_if.rd_gnt), 32'h0);
        check_eq("s29_rst_ifu_gnt", 32'(ifu_if.rd_gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h600, 1'b1, 32'h700, 1'b1);
        check_eq("s29_fresh_lsu_gnt", 32'(lsu_if.rd_gnt), 32'h1);
        check_eq("s29_fresh_ifu_gnt", 32'(ifu_if.rd_gnt), 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("s29_fresh_data", lsu_if.rd_data, 32'hA5A5_0700);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
